// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator and the
// comparison-symbol seven-segment decoder that consumes its result code.
package serial_magnitude_comparator_pkg;

    // Width of the one-hot {eq, gt, lt} result code
    localparam int unsigned RES_W = 3;

    // Result codes; RES_NONE makes the decoder display '-'
    localparam logic [RES_W-1:0] RES_NONE = 3'b000;
    localparam logic [RES_W-1:0] RES_EQ   = 3'b100;
    localparam logic [RES_W-1:0] RES_GT   = 3'b010;
    localparam logic [RES_W-1:0] RES_LT   = 3'b001;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle between a requester (master) and the comparator (slave).
interface serial_magnitude_comparator_if
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator. Walks the latched operands one bit
// per cycle from the top, stops at the first differing bit, pulses done for
// one cycle and holds the one-hot result until the next accepted start.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                          clk,
    input logic                          rst,
    serial_magnitude_comparator_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic [RES_W-1:0] r_result;

    logic             w_accept;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_last_bit;

    assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_a_bit    = r_a[r_idx];
    assign w_b_bit    = r_b[r_idx];
    assign w_last_bit = (r_idx == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave COMPARE on the first differing bit or after bit 0
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = COMPARE;
            end
            COMPARE: begin
                if ((w_a_bit != w_b_bit) || w_last_bit) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = w_accept ? COMPARE : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        bus.busy   = (r_state == COMPARE);
        bus.done   = (r_state == DONE);
        bus.result = r_result;
    end

    // Operand latch, bit-index down-counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_result <= RES_NONE;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_idx    <= IDX_TOP;
            r_result <= RES_NONE;
        end else if (r_state == COMPARE) begin
            if (w_a_bit && !w_b_bit) begin
                r_result <= RES_GT;
            end else if (!w_a_bit && w_b_bit) begin
                r_result <= RES_LT;
            end else if (w_last_bit) begin
                r_result <= RES_EQ;
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed testbench for serial_magnitude_comparator (WIDTH=8).
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    serial_magnitude_comparator_if #(.WIDTH(8)) bus_if ();

    serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Call at a negedge; returns at the negedge after the accepting edge with start low
    task automatic issue_start(input logic [7:0] a, input logic [7:0] b);
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    // Call at the negedge after acceptance; counts edges until done (bounded)
    task automatic wait_done(output int edges, output int busy_cnt, output int early_res);
        edges     = 0;
        busy_cnt  = bus_if.busy ? 1 : 0;
        early_res = (bus_if.result != 3'b000) ? 1 : 0;
        while (edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (bus_if.done) break;
            if (bus_if.busy) busy_cnt++;
            if (bus_if.result != 3'b000) early_res++;
        end
    endtask

    task automatic test_reset();
        int e, bc, er;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus_if.busy, bus_if.done, bus_if.result} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_state: got busy/done/result=%b required 00000",
                     {bus_if.busy, bus_if.done, bus_if.result});
        end
        rst = 1'b0;
        @(negedge clk);
        issue_start(8'hFF, 8'h00);
        wait_done(e, bc, er);
        tests++;
        if (bus_if.result !== 3'b010) begin
            fails++;
            $display("FAIL reset_pre_result: got %b required 010", bus_if.result);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus_if.busy, bus_if.done, bus_if.result} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_async: got busy/done/result=%b required 00000",
                     {bus_if.busy, bus_if.done, bus_if.result});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_differs();
        int e, bc, er;
        issue_start(8'hA5, 8'h25);
        wait_done(e, bc, er);
        tests++;
        if (e !== 1) begin
            fails++;
            $display("FAIL msb_latency: got %0d edges required 1", e);
        end
        tests++;
        if (bus_if.result !== 3'b010 || bus_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL msb_result: got result=%b busy=%b required 010 0", bus_if.result, bus_if.busy);
        end
        tests++;
        if (bc !== 1) begin
            fails++;
            $display("FAIL msb_busy_cycles: got %0d required 1", bc);
        end
        @(negedge clk);
        tests++;
        if (bus_if.done !== 1'b0 || bus_if.result !== 3'b010) begin
            fails++;
            $display("FAIL msb_done_pulse: got done=%b result=%b required 0 010", bus_if.done, bus_if.result);
        end
    endtask

    task automatic test_lsb_differs();
        int e, bc, er;
        issue_start(8'h3C, 8'h3D);
        wait_done(e, bc, er);
        tests++;
        if (e !== 8) begin
            fails++;
            $display("FAIL lsb_latency: got %0d edges required 8", e);
        end
        tests++;
        if (bus_if.result !== 3'b001) begin
            fails++;
            $display("FAIL lsb_result: got %b required 001", bus_if.result);
        end
        tests++;
        if (bc !== 8) begin
            fails++;
            $display("FAIL lsb_busy_cycles: got %0d required 8", bc);
        end
        tests++;
        if (er !== 0) begin
            fails++;
            $display("FAIL lsb_early_result: got %0d nonzero samples required 0", er);
        end
        @(negedge clk);
    endtask

    task automatic test_equal();
        int e, bc, er, bad, pulses;
        issue_start(8'h7E, 8'h7E);
        wait_done(e, bc, er);
        tests++;
        if (e !== 8 || bus_if.result !== 3'b100) begin
            fails++;
            $display("FAIL eq_result: got %0d edges result=%b required 8 100", e, bus_if.result);
        end
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done) pulses++;
            if (bus_if.result !== 3'b100 || bus_if.busy) bad++;
        end
        tests++;
        if (pulses !== 0 || bad !== 0) begin
            fails++;
            $display("FAIL eq_hold: got extra_done=%0d bad_samples=%0d required 0 0", pulses, bad);
        end
    endtask

    task automatic test_start_ignored();
        int pulses;
        issue_start(8'h40, 8'h10);
        bus_if.start = 1'b1;
        bus_if.a     = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        tests++;
        if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 || bus_if.result !== 3'b000) begin
            fails++;
            $display("FAIL ign_mid: got busy=%b done=%b result=%b required 1 0 000",
                     bus_if.busy, bus_if.done, bus_if.result);
        end
        @(negedge clk);
        tests++;
        if (bus_if.done !== 1'b1 || bus_if.result !== 3'b010) begin
            fails++;
            $display("FAIL ign_result: got done=%b result=%b required 1 010", bus_if.done, bus_if.result);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done) pulses++;
        end
        tests++;
        if (pulses !== 0 || bus_if.result !== 3'b010) begin
            fails++;
            $display("FAIL ign_single_done: got extra_done=%0d result=%b required 0 010", pulses, bus_if.result);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc, er, pulses;
        issue_start(8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus_if.busy, bus_if.done, bus_if.result} !== 5'b00000) begin
            fails++;
            $display("FAIL abort_reset: got busy/done/result=%b required 00000",
                     {bus_if.busy, bus_if.done, bus_if.result});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d active samples required 0", pulses);
        end
        issue_start(8'h01, 8'h02);
        wait_done(e, bc, er);
        tests++;
        if (e !== 7 || bus_if.result !== 3'b001) begin
            fails++;
            $display("FAIL b2b_first: got %0d edges result=%b required 7 001", e, bus_if.result);
        end
        bus_if.start = 1'b1;
        bus_if.a     = 8'h80;
        bus_if.b     = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        tests++;
        if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 || bus_if.result !== 3'b000) begin
            fails++;
            $display("FAIL b2b_reaccept: got busy=%b done=%b result=%b required 1 0 000",
                     bus_if.busy, bus_if.done, bus_if.result);
        end
        @(negedge clk);
        tests++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.result !== 3'b010) begin
            fails++;
            $display("FAIL b2b_second: got done=%b busy=%b result=%b required 1 0 010",
                     bus_if.done, bus_if.busy, bus_if.result);
        end
        @(negedge clk);
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        test_reset();
        test_msb_differs();
        test_lsb_differs();
        test_equal();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential, MSB-first magnitude comparator for two unsigned WIDTH-bit operands. It sits directly upstream of the comparison-symbol seven-segment decoder. It produces the 3-bit one-hot code that decoder consumes: `=` is 100, `>` is 010, `<` is 001, and 000 displays `-`. It exits early on the first differing bit and signals completion with a one-cycle `done` pulse, while holding the result for display.

## Interface
- WIDTH, default 8: operand width in bits, minimum 2.
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a comparison. Sampled only in IDLE or DONE.
- a, input, WIDTH: operand A, unsigned. Latched on start acceptance.
- b, input, WIDTH: operand B, unsigned. Latched on start acceptance.
- busy, output, 1: high while in state COMPARE.
- done, output, 1: one-cycle pulse, high while in state DONE.
- result, output, 3: one-hot {eq, gt, lt}. 000 means no valid result.

## Operation
- States:
  - IDLE: waits for start.
  - COMPARE: examines one bit per cycle, from bit WIDTH-1 down to bit 0.
  - DONE: lasts exactly one cycle.
- Start acceptance, in IDLE or DONE with start=1:
  - latch a and b into internal registers;
  - idx <= WIDTH-1;
  - result <= 000;
  - go to COMPARE.
- Start is ignored while in COMPARE. a and b may change freely while busy; the latched copies are used.
- Each COMPARE cycle evaluates the latched bit pair at idx:
  - A[idx]=1, B[idx]=0: result <= 010, go to DONE.
  - A[idx]=0, B[idx]=1: result <= 001, go to DONE.
  - Bits equal and idx==0: result <= 100, go to DONE.
  - Bits equal and idx>0: idx <= idx-1, stay in COMPARE.
- DONE:
  - start=1: accept the new comparison (back-to-back), go to COMPARE.
  - Otherwise: go to IDLE.
  - result holds its value until the next start acceptance.
- result only ever takes the values 000, 100, 010 or 001. It never has more than one bit set.
- idx width is clog2(WIDTH). idx never wraps, because COMPARE always exits at idx==0.

## Timing
- Reset values (asynchronous, take effect immediately): state=IDLE, busy=0, done=0, result=000, idx=0, latched operands=0.
- Latency is counted from the clock edge that accepts start:
  - k is the highest bit index where a and b differ;
  - done is high in the cycle after edge number WIDTH-k;
  - equal operands behave like k=0, so done follows edge WIDTH.
- Minimum latency is 1 edge (MSB differs). Maximum latency is WIDTH edges.
- busy:
  - rises on the start-accepting edge;
  - falls on the same edge that raises done.
- result changes exactly twice per comparison:
  - cleared to 000 on the start-accepting edge;
  - set to its final value on the edge that enters DONE.
- Back-to-back operation: start held high during the DONE cycle gives a 1-cycle done pulse, after which busy immediately goes high again. No IDLE cycle is inserted.
- Reset asserted mid-COMPARE aborts the operation with no done pulse. result returns to 000, so the display shows `-`. The first start after reset deasserts behaves normally.

## Structure
- Shared package or include file, also used by the seven-segment decoder:
  - result code constants: RES_NONE=3'b000, RES_EQ=3'b100, RES_GT=3'b010, RES_LT=3'b001;
  - state encoding localparams: IDLE, COMPARE, DONE.
- Implement as a single module: one FSM block with the idx down-counter and operand registers. No sub-module.
- result connects directly to the decoder's 3-bit input.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst asynchronously between clock edges. Outputs go to busy=0, done=0, result=000 immediately, before the next clock edge.
- MSB differs: a=8'hA5, b=8'h25, start for 1 cycle. Expect done after edge 1, result=010, busy high for exactly 1 cycle.
- LSB differs: a=8'h3C, b=8'h3D. Expect done after edge 8, result=001, busy high for 8 cycles, result=000 until then.
- Equal operands: a=b=8'h7E. Expect result=100 after edge 8. result holds 100 for 20 idle cycles after the single done pulse.
- Start ignored and operands latched:
  - Stimulus: a=8'h40, b=8'h10; while busy, pulse start and change a to 8'h00.
  - Expect result=010 after edge 2 (k=6), and only one done pulse.
- Reset mid-operation then back-to-back:
  - Stimulus: a=b=8'hFF, assert rst after edge 3, release rst, start with a=8'h01, b=8'h02. Then hold start high in the DONE cycle with a=8'h80, b=8'h00.
  - Expect no done pulse for the aborted operation; then result=001 after edge 7 (k=1); then immediately result=010 one edge after the re-accept.
